// File: rtl/img_write_bmp.sv
// rtl/img_write_bmp.sv - serialises pixel pairs into a 24-bit top-down BMP byte stream
module img_write_bmp #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] DATA_R0,
    input  logic [7:0] DATA_G0,
    input  logic [7:0] DATA_B0,
    input  logic [7:0] DATA_R1,
    input  logic [7:0] DATA_G1,
    input  logic [7:0] DATA_B1,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       ctrl_done
);

    localparam int ROWB  = 3 * WIDTH;
    localparam int PAD   = (4 - ROWB % 4) % 4;
    localparam int IMG   = HEIGHT * (ROWB + PAD);
    localparam int FSZ   = 54 + IMG;
    localparam int COL_W = $clog2(WIDTH) + 1;
    localparam int ROW_W = $clog2(HEIGHT) + 1;

    localparam logic [31:0] FSZ_F  = 32'(FSZ);
    localparam logic [31:0] IMG_F  = 32'(IMG);
    localparam logic [31:0] WID_F  = 32'(WIDTH);
    localparam logic [31:0] NEGH_F = 32'(-HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [1:0]       PAD_LAST = 2'((PAD > 0) ? PAD - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PIX, S_PAD, S_DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [5:0]         hdr_idx;
    logic [2:0]         byte_idx;
    logic [1:0]         pad_idx;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [47:0]        pix_buf;

    logic xfer;
    logic beat;
    logic hdr_last;
    logic beat_drained;
    logic row_end;
    logic last_row;
    logic pad_last;

    assign xfer         = out_valid & out_ready;
    assign beat         = in_valid & in_ready;
    assign hdr_last     = (hdr_idx == 6'd53);
    assign beat_drained = (byte_idx == 3'd5);
    assign row_end      = (col == COL_LAST);
    assign last_row     = (row == ROW_LAST);
    assign pad_last     = (pad_idx == PAD_LAST);

    // Header ROM: each byte is picked out of its little-endian 32-bit field.
    function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
        logic [31:0] field;
        logic [5:0]  base;
        logic [1:0]  off;
        field = 32'd0;
        base  = 6'd46;
        if (idx <= 6'd1) begin
            field = 32'h0000_4D42; base = 6'd0;
        end else if (idx <= 6'd5) begin
            field = FSZ_F;         base = 6'd2;
        end else if (idx <= 6'd9) begin
            field = 32'd0;         base = 6'd6;
        end else if (idx <= 6'd13) begin
            field = 32'd54;        base = 6'd10;
        end else if (idx <= 6'd17) begin
            field = 32'd40;        base = 6'd14;
        end else if (idx <= 6'd21) begin
            field = WID_F;         base = 6'd18;
        end else if (idx <= 6'd25) begin
            field = NEGH_F;        base = 6'd22;
        end else if (idx <= 6'd27) begin
            field = 32'd1;         base = 6'd26;
        end else if (idx <= 6'd29) begin
            field = 32'd24;        base = 6'd28;
        end else if (idx <= 6'd33) begin
            field = 32'd0;         base = 6'd30;
        end else if (idx <= 6'd37) begin
            field = IMG_F;         base = 6'd34;
        end else if (idx <= 6'd41) begin
            field = 32'd2835;      base = 6'd38;
        end else if (idx <= 6'd45) begin
            field = 32'd2835;      base = 6'd42;
        end
        off = 2'(idx - base);
        return field[{off, 3'b000} +: 8];
    endfunction

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid) state_next = S_HDR;
            S_HDR:  if (xfer && hdr_last) state_next = S_PIX;
            S_PIX: begin
                if (xfer && beat_drained && row_end) begin
                    if (PAD > 0)       state_next = S_PAD;
                    else if (last_row) state_next = S_DONE;
                end
            end
            S_PAD:  if (xfer && pad_last) state_next = last_row ? S_DONE : S_PIX;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The beat buffer is full exactly while out_valid is high in PIX.
    always_comb begin
        in_ready = (state == S_PIX) && !out_valid;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            ctrl_done <= 1'b0;
            hdr_idx   <= '0;
            byte_idx  <= '0;
            pad_idx   <= '0;
            col       <= '0;
            row       <= '0;
            pix_buf   <= '0;
        end else begin
            if (state_next == S_DONE && state != S_DONE) begin
                ctrl_done <= 1'b1;
            end else if (state == S_IDLE && in_valid) begin
                ctrl_done <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        hdr_idx   <= '0;
                        out_valid <= 1'b1;
                        out_data  <= hdr_byte(6'd0);
                    end
                end
                S_HDR: begin
                    if (xfer) begin
                        if (hdr_last) begin
                            out_valid <= 1'b0;
                            col       <= '0;
                            row       <= '0;
                        end else begin
                            hdr_idx  <= hdr_idx + 6'd1;
                            out_data <= hdr_byte(hdr_idx + 6'd1);
                        end
                    end
                end
                S_PIX: begin
                    if (beat) begin
                        pix_buf   <= {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};
                        byte_idx  <= '0;
                        out_valid <= 1'b1;
                        out_data  <= DATA_B0;
                    end else if (xfer) begin
                        if (!beat_drained) begin
                            byte_idx <= byte_idx + 3'd1;
                            out_data <= pix_buf[{byte_idx + 3'd1, 3'b000} +: 8];
                        end else begin
                            col <= row_end ? '0 : col + COL_W'(2);
                            if (row_end && PAD > 0) begin
                                pad_idx  <= '0;
                                out_data <= 8'd0;
                            end else begin
                                out_valid <= 1'b0;
                                if (row_end && !last_row) row <= row + ROW_W'(1);
                            end
                        end
                    end
                end
                S_PAD: begin
                    if (xfer) begin
                        if (pad_last) begin
                            out_valid <= 1'b0;
                            if (!last_row) row <= row + ROW_W'(1);
                        end else begin
                            pad_idx <= pad_idx + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
